// File: rtl/dz_modem_emu.sv
// dz_modem_emu: eight answer-mode modem emulators driving DZ11 carrier detect and ring indicator
module dz_modem_emu #(
    parameter int TICK_DIV = 50000,
    parameter int RING_ON  = 2000,
    parameter int RING_OFF = 4000,
    parameter int RING_MAX = 6,
    parameter int CO_DELAY = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dzDTR,
    input  logic [7:0] callReq,
    input  logic [7:0] hangReq,
    input  logic [7:0] clrMissed,
    output logic [7:0] dzCO,
    output logic [7:0] dzRI,
    output logic [7:0] missed
);
    typedef enum logic [2:0] {S_IDLE, S_RON, S_ROFF, S_ANS, S_CON} state_t;

    logic [15:0] pre_q, pre_d;
    logic        tick;
    state_t      st_q [8];
    state_t      st_d [8];
    logic [15:0] tmr_q [8];
    logic [15:0] tmr_d [8];
    logic [3:0]  rc_q [8];
    logic [3:0]  rc_d [8];
    logic [7:0]  miss_q, miss_d;
    logic [7:0]  expire;

    function automatic logic [15:0] dur(state_t s);
        return s == S_RON  ? 16'(RING_ON)  :
               s == S_ROFF ? 16'(RING_OFF) :
               s == S_ANS  ? 16'(CO_DELAY) : 16'd0;
    endfunction

    assign tick   = pre_q == 16'(TICK_DIV - 1);
    assign pre_d  = tick ? 16'd0 : pre_q + 16'd1;
    assign missed = miss_q;

    // per-line next state, timer reload on entry, ring count, sticky missed flag and Moore outputs
    always_comb begin
        miss_d = miss_q & ~clrMissed;
        expire = '0;
        dzCO   = '0;
        dzRI   = '0;
        for (int i = 0; i < 8; i++) begin
            st_d[i]   = st_q[i];
            rc_d[i]   = rc_q[i];
            expire[i] = tick && tmr_q[i] == 16'd1;
            tmr_d[i]  = (tick && tmr_q[i] != 16'd0) ? tmr_q[i] - 16'd1 : tmr_q[i];
            case (st_q[i])
                S_IDLE:
                    if (callReq[i] && !hangReq[i]) begin
                        st_d[i] = S_RON;
                        rc_d[i] = 4'd1;
                    end
                S_RON:
                    if (hangReq[i])     st_d[i] = S_IDLE;
                    else if (dzDTR[i])  st_d[i] = S_ANS;
                    else if (expire[i]) st_d[i] = S_ROFF;
                S_ROFF:
                    if (hangReq[i])     st_d[i] = S_IDLE;
                    else if (dzDTR[i])  st_d[i] = S_ANS;
                    else if (expire[i]) begin
                        if (rc_q[i] == 4'(RING_MAX)) begin
                            st_d[i]   = S_IDLE;
                            miss_d[i] = 1'b1;
                        end else begin
                            st_d[i] = S_RON;
                            rc_d[i] = rc_q[i] + 4'd1;
                        end
                    end
                S_ANS:
                    if (hangReq[i] || !dzDTR[i]) st_d[i] = S_IDLE;
                    else if (expire[i])          st_d[i] = S_CON;
                S_CON:
                    if (hangReq[i] || !dzDTR[i]) st_d[i] = S_IDLE;
                default: st_d[i] = S_IDLE;
            endcase
            if (st_d[i] != st_q[i]) tmr_d[i] = dur(st_d[i]);
            dzCO[i] = st_q[i] == S_CON;
            dzRI[i] = st_q[i] == S_RON;
        end
    end

    // shared prescaler and all per-line state registers; reset drops CO/RI at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            miss_q <= '0;
            for (int i = 0; i < 8; i++) begin
                st_q[i]  <= S_IDLE;
                tmr_q[i] <= '0;
                rc_q[i]  <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            miss_q <= miss_d;
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            rc_q   <= rc_d;
        end
    end
endmodule

// File: tb/tb_dz_modem_emu.sv
// tb_dz_modem_emu: table-driven cycle vectors with a scoreboard queue for dz_modem_emu
module tb_dz_modem_emu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dtr = '0, call = '0, hang = '0, clr = '0;
    logic [7:0] co, ri, miss;
    int         passed = 0, total = 0;

    typedef struct {
        int         n;
        logic [7:0] dtr, call, hang, clr, co, ri, miss;
    } vec_t;
    typedef struct packed {
        logic [7:0] co, ri, miss;
    } exp_t;

    vec_t vt [34];
    exp_t sb [$];

    always #5 clk = ~clk;

    dz_modem_emu #(
        .TICK_DIV(4), .RING_ON(2), .RING_OFF(3), .RING_MAX(2), .CO_DELAY(2)
    ) dut (
        .clk(clk), .rst(rst), .dzDTR(dtr), .callReq(call), .hangReq(hang),
        .clrMissed(clr), .dzCO(co), .dzRI(ri), .missed(miss)
    );

    task automatic check(input string name, input exp_t e);
        total++;
        if ({co, ri, miss} === e) passed++;
        else $display("FAIL %s: got co=%h ri=%h missed=%h, want co=%h ri=%h missed=%h",
                      name, co, ri, miss, e.co, e.ri, e.miss);
    endtask

    task automatic step(input string name, input vec_t v, input bit first);
        exp_t e;
        dtr  = v.dtr;
        call = first ? v.call : 8'h00;
        hang = first ? v.hang : 8'h00;
        clr  = first ? v.clr  : 8'h00;
        sb.push_back('{v.co, v.ri, v.miss});
        @(posedge clk);
        #1;
        call = '0;
        hang = '0;
        clr  = '0;
        e = sb.pop_front();
        check(name, e);
    endtask

    task automatic run(input int lo, input int hi);
        for (int k = lo; k <= hi; k++)
            for (int j = 0; j < vt[k].n; j++)
                step($sformatf("row%0d.%0d", k, j), vt[k], j == 0);
    endtask

    initial begin
        //          n   dtr    call   hang   clr    co     ri     missed
        vt[0]  = '{ 1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        vt[1]  = '{ 6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        vt[2]  = '{12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[3]  = '{ 8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        vt[4]  = '{12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[5]  = '{ 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vt[6]  = '{ 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vt[7]  = '{ 1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        vt[8]  = '{ 1, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
        vt[9]  = '{ 1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[10] = '{ 5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[11] = '{ 1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
        vt[12] = '{ 3, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
        vt[13] = '{ 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[14] = '{ 1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
        vt[15] = '{ 6, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[16] = '{ 2, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00};
        vt[17] = '{ 1, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[18] = '{ 2, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[19] = '{ 1, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[20] = '{ 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[21] = '{ 1, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
        vt[22] = '{ 4, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[23] = '{ 7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[24] = '{ 1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        vt[25] = '{ 6, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00};
        vt[26] = '{12, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
        vt[27] = '{ 8, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hF0, 8'h00};
        vt[28] = '{12, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
        vt[29] = '{ 1, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'h00, 8'hF0};
        vt[30] = '{ 2, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0};
        vt[31] = '{ 1, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
        vt[32] = '{ 6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
        vt[33] = '{ 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", '0);
        run(0, 30);

        #2;
        rst = 1'b1;
        #1;
        check("reset_async_mid_connect", '0);
        @(posedge clk);
        @(negedge clk);
        dtr = '0;
        rst = 1'b0;
        check("reset_release", '0);
        run(31, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
